// File: rtl/game_control.sv
// Game sequencer for a lane-dodging runner: paces frames, drives the drawing
// datapath phase by phase and keeps tree position, lane, shapes and score.
module game_control #(
    parameter int unsigned FRAME_DIV  = 833333,
    parameter logic [7:0]  TREE_START = 8'd156
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       go,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_crouch,
    input  logic       draw_floors_finish,
    input  logic       erase_finish,
    input  logic       draw_tree_finish,
    input  logic       draw_man_finish,
    output logic       drawing_floors,
    output logic       erase,
    output logic       draw_tree,
    output logic       draw_man,
    output logic       plot,
    output logic       ld_x,
    output logic [7:0] x_in,
    output logic       ld_y,
    output logic [6:0] y_in,
    output logic       ld_man_style,
    output logic       man_style,
    output logic       ld_shape,
    output logic [1:0] top,
    output logic [1:0] mid,
    output logic [1:0] bottom,
    output logic       update,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int unsigned    CNT_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [7:0]     LFSR_SEED = 8'hA5;
    localparam logic [1:0]     SH_NONE   = 2'b00;
    localparam logic [1:0]     SH_GAP    = 2'b10;
    localparam logic [1:0]     SH_BLOCK  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FLOORS, S_WAIT_FRAME, S_ERASE, S_TREE, S_MAN, S_UPDATE, S_GAME_OVER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_pend;
    logic             up_pend;
    logic             down_pend;
    logic             key_up_q;
    logic             key_down_q;
    logic [7:0]       lfsr;
    logic [1:0]       lane;
    logic             hit;

    logic       frame_wrap;
    logic       up_req;
    logic       down_req;
    logic       enter_update;
    logic       clear_pend;
    logic       tree_wrap;
    logic [7:0] tx_next;
    logic [1:0] lane_next;
    logic [1:0] gap_lane;
    logic [1:0] fill;
    logic [1:0] top_next;
    logic [1:0] mid_next;
    logic [1:0] bottom_next;
    logic [1:0] lane_shape;
    logic       style_next;
    logic       hit_next;

    assign frame_wrap   = (frame_cnt == CNT_LAST);
    assign up_req       = up_pend | (key_up & ~key_up_q);
    assign down_req     = down_pend | (key_down & ~key_down_q);
    assign enter_update = (state == S_WAIT_FRAME) && frame_pend;
    assign clear_pend   = (state == S_GAME_OVER) && go;
    assign tree_wrap    = (x_in == 8'd0);
    assign plot         = drawing_floors | erase | draw_tree | draw_man;

    // Everything the next UPDATE will load, evaluated from current state.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tx_next   = tree_wrap ? TREE_START : x_in - 8'd1;
        lane_next = lane;
        if (up_req && !down_req && lane != 2'd0)
            lane_next = lane - 2'd1;
        else if (down_req && !up_req && lane != 2'd2)
            lane_next = lane + 2'd1;

        gap_lane    = (lfsr[1:0] == 2'd3) ? 2'd2 : lfsr[1:0];
        fill        = lfsr[2] ? SH_BLOCK : SH_NONE;
        top_next    = top;
        mid_next    = mid;
        bottom_next = bottom;
        if (tree_wrap) begin
            top_next    = (gap_lane == 2'd0) ? SH_GAP : fill;
            mid_next    = (gap_lane == 2'd1) ? SH_GAP : fill;
            bottom_next = (gap_lane == 2'd2) ? SH_GAP : fill;
        end

        case (lane_next)
            2'd0:    lane_shape = top_next;
            2'd1:    lane_shape = mid_next;
            default: lane_shape = bottom_next;
        endcase

        style_next = ~key_crouch;
        // Standing in a gap lane still hits the tree; only a crouch gets through.
        hit_next   = (tx_next >= 8'd24) && (tx_next <= 8'd31) &&
                     ((lane_shape != SH_GAP) || style_next);
    end

    always_comb begin
        case (lane)
            2'd0:    y_in = 7'd28;
            2'd1:    y_in = 7'd68;
            default: y_in = 7'd108;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            frame_cnt      <= '0;
            frame_pend     <= 1'b0;
            up_pend        <= 1'b0;
            down_pend      <= 1'b0;
            key_up_q       <= 1'b0;
            key_down_q     <= 1'b0;
            lfsr           <= LFSR_SEED;
            lane           <= 2'd2;
            hit            <= 1'b0;
            drawing_floors <= 1'b0;
            erase          <= 1'b0;
            draw_tree      <= 1'b0;
            draw_man       <= 1'b0;
            ld_x           <= 1'b0;
            ld_y           <= 1'b0;
            ld_man_style   <= 1'b0;
            ld_shape       <= 1'b0;
            update         <= 1'b0;
            x_in           <= TREE_START;
            man_style      <= 1'b1;
            top            <= SH_NONE;
            mid            <= SH_GAP;
            bottom         <= SH_BLOCK;
            score          <= 8'd0;
            game_over      <= 1'b0;
        end else begin
            lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            frame_cnt    <= frame_wrap ? '0 : frame_cnt + 1'b1;
            key_up_q     <= key_up;
            key_down_q   <= key_down;
            ld_x         <= 1'b0;
            ld_y         <= 1'b0;
            ld_man_style <= 1'b0;
            ld_shape     <= 1'b0;
            update       <= 1'b0;

            // Ticks landing outside WAIT_FRAME stay pending and merge into one.
            if (clear_pend) begin
                frame_pend <= 1'b0;
                up_pend    <= 1'b0;
                down_pend  <= 1'b0;
            end else begin
                frame_pend <= frame_wrap | (frame_pend & ~enter_update);
                up_pend    <= ~enter_update & up_req;
                down_pend  <= ~enter_update & down_req;
            end

            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (go) begin
                        state          <= S_FLOORS;
                        drawing_floors <= 1'b1;
                        game_over      <= 1'b0;
                        x_in           <= TREE_START;
                        lane           <= 2'd2;
                        top            <= SH_NONE;
                        mid            <= SH_GAP;
                        bottom         <= SH_BLOCK;
                        man_style      <= 1'b1;
                        score          <= 8'd0;
                        ld_x           <= 1'b1;
                        ld_y           <= 1'b1;
                        ld_man_style   <= 1'b1;
                        ld_shape       <= 1'b1;
                    end
                end
                S_FLOORS: begin
                    if (draw_floors_finish) begin
                        drawing_floors <= 1'b0;
                        state          <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame_pend) begin
                        state        <= S_UPDATE;
                        update       <= 1'b1;
                        ld_x         <= 1'b1;
                        ld_y         <= 1'b1;
                        ld_man_style <= 1'b1;
                        ld_shape     <= tree_wrap;
                        x_in         <= tx_next;
                        lane         <= lane_next;
                        top          <= top_next;
                        mid          <= mid_next;
                        bottom       <= bottom_next;
                        man_style    <= style_next;
                        hit          <= hit_next;
                        if (tree_wrap && score != 8'hFF)
                            score <= score + 8'd1;
                    end
                end
                S_UPDATE: begin
                    if (hit) begin
                        state     <= S_GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= S_ERASE;
                        erase <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (erase_finish) begin
                        erase     <= 1'b0;
                        draw_tree <= 1'b1;
                        state     <= S_TREE;
                    end
                end
                S_TREE: begin
                    if (draw_tree_finish) begin
                        draw_tree <= 1'b0;
                        draw_man  <= 1'b1;
                        state     <= S_MAN;
                    end
                end
                S_MAN: begin
                    if (draw_man_finish) begin
                        draw_man <= 1'b0;
                        state    <= S_WAIT_FRAME;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: stub datapath, game-level reference model checked
// every cycle, and directed game scenarios with literal expectations.
module tb_game_control;

    localparam int FRAME_DIV  = 4;
    localparam int TREE_START = 156;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       go = 1'b0, key_up = 1'b0, key_down = 1'b0, key_crouch = 1'b0;
    logic       draw_floors_finish = 1'b0, erase_finish = 1'b0;
    logic       draw_tree_finish = 1'b0, draw_man_finish = 1'b0;
    logic       drawing_floors, erase, draw_tree, draw_man, plot;
    logic       ld_x, ld_y, ld_man_style, man_style, ld_shape, update, game_over;
    logic [7:0] x_in, score;
    logic [6:0] y_in;
    logic [1:0] top, mid, bottom;

    int checks = 0;
    int failures = 0;
    int lat_floors = 3, lat_erase = 3, lat_tree = 3, lat_man = 3;

    game_control #(.FRAME_DIV(FRAME_DIV), .TREE_START(8'd156)) dut (
        .clk(clk), .reset_n(reset_n), .go(go),
        .key_up(key_up), .key_down(key_down), .key_crouch(key_crouch),
        .draw_floors_finish(draw_floors_finish), .erase_finish(erase_finish),
        .draw_tree_finish(draw_tree_finish), .draw_man_finish(draw_man_finish),
        .drawing_floors(drawing_floors), .erase(erase), .draw_tree(draw_tree),
        .draw_man(draw_man), .plot(plot), .ld_x(ld_x), .x_in(x_in), .ld_y(ld_y),
        .y_in(y_in), .ld_man_style(ld_man_style), .man_style(man_style),
        .ld_shape(ld_shape), .top(top), .mid(mid), .bottom(bottom),
        .update(update), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stub datapath: each phase reports finished after its latency in cycles.
    initial begin
        int c_fl, c_er, c_tr, c_mn;
        c_fl = 0; c_er = 0; c_tr = 0; c_mn = 0;
        forever begin
            @(negedge clk);
            c_fl = drawing_floors ? c_fl + 1 : 0;
            c_er = erase ? c_er + 1 : 0;
            c_tr = draw_tree ? c_tr + 1 : 0;
            c_mn = draw_man ? c_mn + 1 : 0;
            draw_floors_finish = drawing_floors && (c_fl >= lat_floors);
            erase_finish       = erase && (c_er >= lat_erase);
            draw_tree_finish   = draw_tree && (c_tr >= lat_tree);
            draw_man_finish    = draw_man && (c_mn >= lat_man);
        end
    end

    // Reference LFSR; m_lfsr_used is the value in effect at the last clock edge.
    logic [7:0] m_lfsr, m_lfsr_used;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_lfsr      <= 8'hA5;
            m_lfsr_used <= 8'hA5;
        end else begin
            m_lfsr_used <= m_lfsr;
            m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    // Game-level model: advanced once per observed frame update.
    int   m_tx, m_lane, m_score, m_sh[3];
    int   y_of[3] = '{28, 68, 108};
    bit   m_up, m_dn, m_style, m_hit, m_go, after_upd;
    logic [3:0] prev_ph, last_nz;
    int   mw_g, mw_fill, mw_txn;
    bit   mw_wrap, first_fl;
    logic [3:0] ph;

    task automatic model_restart();
        m_tx = TREE_START; m_lane = 2; m_score = 0; m_style = 1'b1;
        m_sh[0] = 0; m_sh[1] = 2; m_sh[2] = 3;
        m_up = 1'b0; m_dn = 1'b0; m_hit = 1'b0; m_go = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            model_restart();
            after_upd = 1'b0; prev_ph = 4'b0; last_nz = 4'b0;
        end else begin
            ph = {drawing_floors, erase, draw_tree, draw_man};
            check("one_phase", 32'($countones(ph) <= 1), 1);
            check("plot", plot, |ph);
            first_fl = (ph == 4'b1000) && (prev_ph != 4'b1000);
            if (first_fl) begin
                model_restart();
                check("restart_strobes", {ld_x, ld_y, ld_man_style, ld_shape}, 4'hF);
                check("restart_x", x_in, TREE_START);
                check("restart_y", y_in, 108);
                check("restart_style", man_style, 1);
                check("restart_shapes", {top, mid, bottom}, 6'b00_10_11);
                check("restart_score", score, 0);
            end
            if (after_upd) begin
                m_go = m_hit;
                check("erase_after_update", erase, !m_hit);
                after_upd = 1'b0;
            end
            if (update) begin
                check("update_follows_man", 32'((last_nz == 4'b0001) || (last_nz == 4'b1000)), 1);
                last_nz = 4'b0;
                mw_wrap = (m_tx == 0);
                mw_txn  = mw_wrap ? TREE_START : m_tx - 1;
                if (m_up && !m_dn) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
                else if (m_dn && !m_up) m_lane = (m_lane < 2) ? m_lane + 1 : 2;
                m_up = 1'b0; m_dn = 1'b0;
                if (mw_wrap) begin
                    mw_g = int'(m_lfsr_used[1:0]);
                    if (mw_g == 3) mw_g = 2;
                    mw_fill = m_lfsr_used[2] ? 3 : 0;
                    for (int i = 0; i < 3; i++) m_sh[i] = (i == mw_g) ? 2 : mw_fill;
                    if (m_score < 255) m_score++;
                end
                m_tx    = mw_txn;
                m_style = !key_crouch;
                m_hit   = (mw_txn >= 24) && (mw_txn <= 31) && ((m_sh[m_lane] != 2) || m_style);
                check("upd_strobes", {ld_x, ld_y, ld_man_style}, 3'b111);
                check("upd_ld_shape", ld_shape, mw_wrap);
                check("upd_x", x_in, m_tx);
                check("upd_y", y_in, y_of[m_lane]);
                check("upd_style", man_style, m_style);
                check("upd_shapes", {top, mid, bottom},
                      {m_sh[0][1:0], m_sh[1][1:0], m_sh[2][1:0]});
                check("upd_score", score, m_score);
                after_upd = 1'b1;
            end else if (!first_fl) begin
                check("no_strobe", {ld_x, ld_y, ld_man_style, ld_shape}, 0);
            end
            check("game_over", game_over, m_go);
            if (m_go) begin
                check("gameover_quiet", ph, 0);
                check("gameover_score", score, m_score);
            end
            if (ph != 4'b0) last_nz = ph;
            prev_ph = ph;
        end
    end

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn);
        @(negedge clk);
        key_up = up; key_down = dn;
        if (up) m_up = 1'b1;
        if (dn) m_dn = 1'b1;
        @(negedge clk);
        key_up = 1'b0; key_down = 1'b0;
    endtask

    task automatic wait_update(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (update) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_update", 0, 1);
    endtask

    task automatic wait_game_over(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (game_over) begin ok = 1'b1; break; end
        end
        if (!ok) check("timeout_game_over", 0, 1);
    endtask

    initial begin
        int n10;
        bit ok;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_plot", plot, 0);
        check("rst_enables", {drawing_floors, erase, draw_tree, draw_man}, 0);
        check("rst_strobes", {ld_x, ld_y, ld_man_style, ld_shape, update}, 0);
        check("rst_game_over", game_over, 0);
        check("rst_x", x_in, 156);
        check("rst_y", y_in, 108);
        check("rst_shapes", {top, mid, bottom}, 6'b00_10_11);
        check("rst_style", man_style, 1);
        check("rst_score", score, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_holds", plot, 0);

        // First frame, then a standing runner in lane 2 hits the blocked bottom lane.
        pulse_go();
        check("go_floors", drawing_floors, 1);
        wait_update(100);
        check("first_x", x_in, 155);
        check("first_y", y_in, 108);
        wait_game_over(5000);
        check("hit_x", x_in, 31);
        check("hit_y", y_in, 108);
        check("hit_score", score, 0);
        check("hit_quiet", plot, 0);

        // Restart; one up-move into the gap lane, but standing still collides.
        pulse_go();
        check("restart_score_lit", score, 0);
        check("restart_ldx_lit", ld_x, 1);
        wait_update(100);
        press(1'b1, 1'b0);
        wait_update(100);
        check("gap_lane_y", y_in, 68);
        wait_game_over(5000);
        check("stand_hit_x", x_in, 31);
        check("stand_hit_y", y_in, 68);

        // Lane moves: up, up, saturate, both-at-once, down.
        pulse_go();
        wait_update(100);
        press(1'b1, 1'b0); wait_update(100); check("up1_y", y_in, 68);
        press(1'b1, 1'b0); wait_update(100); check("up2_y", y_in, 28);
        press(1'b1, 1'b0); wait_update(100); check("up3_sat_y", y_in, 28);
        press(1'b1, 1'b1); wait_update(100); check("both_y", y_in, 28);
        press(1'b0, 1'b1); wait_update(100); check("down_y", y_in, 68);
        wait_game_over(5000);
        check("lanes_hit_x", x_in, 31);

        // Crouching through the gap lane survives until the tree wraps.
        key_crouch = 1'b1;
        pulse_go();
        check("style_reset_lit", man_style, 1);
        wait_update(100);
        press(1'b1, 1'b0);
        wait_update(100);
        check("crouch_style", man_style, 0);
        check("crouch_y", y_in, 68);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wait_update(100);
            if (ld_shape) begin ok = 1'b1; break; end
        end
        check("wrap_seen", ok, 1);
        check("wrap_x", x_in, 156);
        check("wrap_score", score, 1);
        n10 = 0;
        if (top == 2'b10) n10++;
        if (mid == 2'b10) n10++;
        if (bottom == 2'b10) n10++;
        check("wrap_one_gap", n10, 1);
        check("wrap_no_over", game_over, 0);
        repeat (20) wait_update(100);

        // Tree phase longer than a frame: ticks must merge into a single update.
        lat_tree = 10;
        repeat (6) wait_update(100);
        lat_tree = 3;
        wait_update(100);

        // Asynchronous reset in the middle of ERASE.
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (erase) begin ok = 1'b1; break; end
        end
        check("erase_seen", ok, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_erase", erase, 0);
        check("arst_plot", plot, 0);
        check("arst_score", score, 0);
        check("arst_x", x_in, 156);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_idle", plot, 0);
        pulse_go();
        wait_update(100);
        check("arst_first_x", x_in, 155);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
